rsa_msg_sequencer: RTL

- Upstream feeder for the RSA encryption core, which computes message^private_key mod public_key.
- Buffers a stream of 16-bit plaintext words in a small FIFO.
- Launches one core calculation per word with a single-cycle start pulse, waits for the core's done flag, and presents each ciphertext on a valid/ready output port in input order.
- Provides a per-job timeout and a completed-job counter.

---
 rtl/rsa_msg_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_msg_sequencer.sv
// Feeds buffered 16-bit plaintext words to the RSA core one job at a time and
// returns ciphertexts in order. Optional range check: define RSA_RANGE_CHECK_EN.
module rsa_msg_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prv_key,
  input  logic [15:0]      pub_key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_msg,
  output logic             core_start,
  output logic [15:0]      core_message,
  output logic [15:0]      core_private_key,
  output logic [15:0]      core_public_key,
  input  logic             core_cal_done,
  input  logic [15:0]      core_cal_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_val,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic             timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_CLEAR,
    S_BUSY,
    S_OUTPUT
  } state_t;

  state_t state, state_next;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [15:0]   head;
  logic [TW-1:0] tmr;

  logic push, pop, launch_load, res_ok, res_to, res_range, hs, range_bad;

  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];
  assign busy = (state != S_IDLE);

`ifdef RSA_RANGE_CHECK_EN
  assign range_bad = (head >= pub_key) || (pub_key < 16'd2);
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_msg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    launch_load = 1'b0;
    res_ok      = 1'b0;
    res_to      = 1'b0;
    res_range   = 1'b0;
    hs          = 1'b0;
    core_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && !timeout) begin
          pop         = 1'b1;
          launch_load = 1'b1;
          if (range_bad) begin
            res_range  = 1'b1;
            state_next = S_OUTPUT;
          end else begin
            state_next = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        state_next = S_CLEAR;
      end
      // A done level left over from the previous job must drop before we wait for a new one.
      S_CLEAR: begin
        if (tmr == TMO_LAST) begin
          res_to     = 1'b1;
          state_next = S_OUTPUT;
        end else if (!core_cal_done) begin
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_cal_done) begin
          res_ok     = 1'b1;
          state_next = S_OUTPUT;
        end else if (tmr == TMO_LAST) begin
          res_to     = 1'b1;
          state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          hs         = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr              <= '0;
      core_message     <= '0;
      core_private_key <= '0;
      core_public_key  <= '0;
      out_valid        <= 1'b0;
      out_val          <= '0;
      out_err          <= 1'b0;
      job_count        <= '0;
      timeout          <= 1'b0;
    end else begin
      if (state == S_LAUNCH)
        tmr <= '0;
      else if ((state == S_CLEAR) || (state == S_BUSY))
        tmr <= tmr + 1'b1;

      if (launch_load) begin
        core_message     <= head;
        core_private_key <= prv_key;
        core_public_key  <= pub_key;
      end

      if (res_ok) begin
        out_val   <= core_cal_val;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (res_to || res_range) begin
        out_val   <= '0;
        out_err   <= 1'b1;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
        job_count <= job_count + CNT_W'(1);
      end

      if (res_to) timeout <= 1'b1;
    end
  end

endmodule
